rdata_response_arbiter: RTL

RDATA_RESPONSE_ARBITER -- requirements
Module: rdata_response_arbiter

---
 rtl/rdata_response_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rdata_response_arbiter.sv
// Read-data response arbiter: routes one master read to the lowest-index
// decoded slave, waits for its data (bounded by an optional timeout) and
// returns a single-cycle response. Decode misses and timeouts answer with
// ERR_DATA and rerr=1.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | no transaction; a ren is accepted here
//   WAIT   | slave selected, slave_ren held, counting toward timeout
//   RESP   | one-cycle response strobe to the master
module rdata_response_arbiter #(
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hBAD1_BAD1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             ren,
  input  logic [NUM_SLAVES-1:0]            addr_valid,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_rdata,
  input  logic [NUM_SLAVES-1:0]            slave_rvalid,
  output logic [NUM_SLAVES-1:0]            slave_ren,
  output logic                             busy,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             rvalid,
  output logic                             rerr
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  // Counter saturates at TIMEOUT_CYCLES; with the timeout disabled it just
  // parks at 1 and is never compared.
  localparam logic [CW-1:0] CNT_SAT  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1);
  // Terminal count is seen in the last WAIT cycle, so exactly
  // TIMEOUT_CYCLES WAIT cycles elapse before the error response.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [DATA_WIDTH-1:0] ERR_D = DATA_WIDTH'(ERR_DATA);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] rd_arr [NUM_SLAVES];
  logic [SW-1:0]         hit_sel;
  logic                  hit_any;

  for (genvar g = 0; g < int'(NUM_SLAVES); g++) begin : g_unpack
    assign rd_arr[g] = slave_rdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Fixed-priority pick of the lowest-index decode hit (slave 0 highest)
  always_comb begin
    hit_sel = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (addr_valid[i]) hit_sel = SW'(i);
    end
  end

  assign hit_any = |addr_valid;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Transaction context registers: selected slave, wait counter, response
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  // Next-state and context update
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (ren) begin
          if (hit_any) begin
            sel_d = hit_sel;
            if (slave_rvalid[hit_sel]) begin
              data_d  = rd_arr[hit_sel];
              err_d   = 1'b0;
              state_d = S_RESP;
            end else begin
              cnt_d   = '0;
              state_d = S_WAIT;
            end
          end else begin
            data_d  = ERR_D;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        // Real data beats a simultaneous terminal count
        if (slave_rvalid[sel_q]) begin
          data_d  = rd_arr[sel_q];
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          data_d  = ERR_D;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: slave enable, busy and the gated response
  always_comb begin
    slave_ren = '0;
    if (!RST) begin
      if (state_q == S_IDLE && ren && hit_any) slave_ren[hit_sel] = 1'b1;
      else if (state_q == S_WAIT)              slave_ren[sel_q]   = 1'b1;
    end
    busy   = (state_q != S_IDLE);
    rvalid = (state_q == S_RESP);
    rdata  = rvalid ? data_q : '0;
    rerr   = rvalid & err_q;
  end

endmodule
